ce_seq_acc: RTL and testbench

Time-multiplexed convolution engine: accepts one output pixel's receptive field as a stream of channel groups (PAR input channels per beat), computes the KERNEL×KERNEL dot product for each channel, accumulates across all CL_IN channels with a bias, then applies rounding shift, optional ReLU and saturation. It replaces the fully parallel per-pixel engine where CL_IN is too large to instantiate every channel. It sits between the line-buffer/window generator and the output feature-map writer, with valid/ready handshakes on both sides.

---
 rtl/ce_seq_acc_pkg.sv | 38 +++
 rtl/ce_seq_acc_dot.sv | 28 ++
 rtl/ce_seq_acc.sv | 154 +++++++++++++++
 tb/tb_ce_seq_acc.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_seq_acc_pkg.sv
// Shared helpers and types for the sequential convolution accumulator.
package ce_pkg;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int acc_w(
        input int n,
        input int m,
        input int k,
        input int cl_in,
        input int bias_w
    );
        int p;
        p = n + m + 1 + clog2(k * k * cl_in);
        return ((p > bias_w) ? p : bias_w) + 1;
    endfunction

    function automatic int beats(input int cl_in, input int par);
        return cl_in / par;
    endfunction

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/ce_seq_acc_dot.sv
// Combinational PAR x K x K multiply-accumulate for one input beat.
module ce_dot
    import ce_pkg::*;
#(
    parameter int PAR    = 4,
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    localparam int TAPS  = PAR * KERNEL * KERNEL,
    localparam int DOT_W = N + M + 1 + clog2(TAPS)
) (
    input  logic [TAPS*N-1:0]       data,
    input  logic [TAPS*M-1:0]       w,
    output logic signed [DOT_W-1:0] sum
);

    typedef logic signed [N+M:0] prod_t;

    // Data is unsigned: a zero MSB makes it a non-negative signed operand.
    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum = sum + DOT_W'(prod_t'($signed({1'b0, data[i*N +: N]}))
                             * prod_t'($signed(w[i*M +: M])));
        end
    end

endmodule

// File: rtl/ce_seq_acc.sv
// Time-multiplexed convolution engine: accumulates CL_IN channels in
// PAR-channel beats, then rounds, shifts, optionally ReLUs and saturates.
module ce_seq_acc
    import ce_pkg::*;
#(
    parameter int CL_IN  = 16,
    parameter int PAR    = 4,
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int BIAS_W = 16,
    parameter int SR     = 2,
    parameter int OUT_W  = 8,
    parameter int RELU   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [PAR*KERNEL*KERNEL*N-1:0]      data2conv,
    input  logic [PAR*KERNEL*KERNEL*M-1:0]      w,
    input  logic signed [BIAS_W-1:0]            bias,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_W-1:0]                    d_out,
    output logic                                ovf
);

    localparam int TAPS  = PAR * KERNEL * KERNEL;
    localparam int BEATS = beats(CL_IN, PAR);
    localparam int ACC_W = acc_w(N, M, KERNEL, CL_IN, BIAS_W);
    localparam int DOT_W = N + M + 1 + clog2(TAPS);
    localparam int CNT_W = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam int PW0   = (ACC_W > SR) ? ACC_W : SR;
    localparam int PW    = ((PW0 > OUT_W) ? PW0 : OUT_W) + 2;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [PW-1:0]    pw_t;

    localparam pw_t RND   = (SR > 0) ? (pw_t'(1) <<< ((SR > 0) ? SR - 1 : 0))
                                     : pw_t'(0);
    localparam pw_t U_MAX = (pw_t'(1) <<< OUT_W) - pw_t'(1);
    localparam pw_t S_MAX = (pw_t'(1) <<< (OUT_W - 1)) - pw_t'(1);
    localparam pw_t S_MIN = -(pw_t'(1) <<< (OUT_W - 1));

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    acc_t                     acc;
    acc_t                     acc_sum;
    logic signed [DOT_W-1:0]  dot_sum;
    logic signed [DOT_W-1:0]  dot_reg;
    logic                     in_ready_q;
    logic                     accept;
    logic                     first;
    logic                     last;
    pw_t                      r;
    logic [OUT_W-1:0]         post_d;
    logic                     post_ovf;

    ce_dot #(
        .PAR    (PAR),
        .KERNEL (KERNEL),
        .N      (N),
        .M      (M)
    ) u_dot (
        .data (data2conv),
        .w    (w),
        .sum  (dot_sum)
    );

    assign in_ready = in_ready_q && !rst;

    always_comb begin
        accept  = in_valid && in_ready;
        first   = (cnt == '0);
        last    = (cnt == CNT_W'(BEATS - 1));
        acc_sum = acc + acc_t'(dot_reg);
    end

    always_comb begin
        r        = (pw_t'(acc_sum) + RND) >>> SR;
        post_d   = r[OUT_W-1:0];
        post_ovf = 1'b0;
        if (RELU != 0) begin
            if (r[PW-1]) begin
                post_d = '0;
            end else if (r > U_MAX) begin
                post_d   = '1;
                post_ovf = 1'b1;
            end
        end else begin
            if (r > S_MAX) begin
                post_d   = {1'b0, {(OUT_W-1){1'b1}}};
                post_ovf = 1'b1;
            end else if (r < S_MIN) begin
                post_d   = {1'b1, {(OUT_W-1){1'b0}}};
                post_ovf = 1'b1;
            end
        end
    end

    // acc trails the accepted beats by one cycle; FLUSH folds in the last
    // dot_reg while producing the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ACC;
            cnt        <= '0;
            acc        <= '0;
            dot_reg    <= '0;
            in_ready_q <= 1'b1;
            out_valid  <= 1'b0;
            d_out      <= '0;
            ovf        <= 1'b0;
        end else begin
            unique case (state)
                ST_ACC: begin
                    dot_reg <= accept ? dot_sum : '0;
                    acc     <= (accept && first) ? acc_t'(bias) + acc_sum
                                                 : acc_sum;
                    if (accept) begin
                        if (last) begin
                            state      <= ST_FLUSH;
                            in_ready_q <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    d_out     <= post_d;
                    ovf       <= post_ovf;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    dot_reg   <= '0;
                    cnt       <= '0;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        in_ready_q <= 1'b1;
                        state      <= ST_ACC;
                    end
                end
                default: begin
                    state      <= ST_ACC;
                    in_ready_q <= 1'b1;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ce_seq_acc.sv
// Bench for ce_seq_acc: directed and random groups against a protocol-level model.
module tb_ce_seq_acc;

    localparam int CL_IN  = 16;
    localparam int PAR    = 4;
    localparam int KERNEL = 3;
    localparam int N      = 4;
    localparam int M      = 4;
    localparam int BIAS_W = 16;
    localparam int SR     = 2;
    localparam int OUT_W  = 8;
    localparam int TAPS   = PAR * KERNEL * KERNEL;
    localparam int BEATS  = CL_IN / PAR;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     out_ready = 1'b1;
    logic [TAPS*N-1:0]        data2conv = '0;
    logic [TAPS*M-1:0]        w = '0;
    logic signed [BIAS_W-1:0] bias = '0;

    logic             in_ready, out_valid, ovf;
    logic [OUT_W-1:0] d_out;
    logic             s_in_ready, s_out_valid, s_ovf;
    logic [OUT_W-1:0] s_d_out;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int last_hs_cyc = 0;
    bit rnd_or = 1'b0;

    int     m_beats = 0;
    longint m_f = 0;
    bit     m_flush = 1'b0;
    bit     m_hold = 1'b0;
    longint m_eu = 0, m_es = 0;
    bit     m_ou = 1'b0, m_os = 1'b0;

    ce_seq_acc #(
        .CL_IN(CL_IN), .PAR(PAR), .KERNEL(KERNEL), .N(N), .M(M),
        .BIAS_W(BIAS_W), .SR(SR), .OUT_W(OUT_W), .RELU(1)
    ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data2conv(data2conv), .w(w), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .d_out(d_out), .ovf(ovf)
    );

    ce_seq_acc #(
        .CL_IN(CL_IN), .PAR(PAR), .KERNEL(KERNEL), .N(N), .M(M),
        .BIAS_W(BIAS_W), .SR(SR), .OUT_W(OUT_W), .RELU(0)
    ) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .data2conv(data2conv), .w(w), .bias(bias),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .d_out(s_d_out), .ovf(s_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic longint beat_sum();
        longint s;
        s = 0;
        for (int i = 0; i < TAPS; i++) begin
            s += longint'(data2conv[i*N +: N]) * longint'($signed(w[i*M +: M]));
        end
        return s;
    endfunction

    function automatic void post(input longint f, input bit relu,
                                 output longint v, output bit o);
        longint r;
        r = (f + (longint'(1) <<< (SR - 1))) >>> SR;
        v = r;
        o = 1'b0;
        if (relu) begin
            if (r < 0) v = 0;
            else if (r > (longint'(1) <<< OUT_W) - 1) begin
                v = (longint'(1) <<< OUT_W) - 1;
                o = 1'b1;
            end
        end else begin
            if (r > (longint'(1) <<< (OUT_W - 1)) - 1) begin
                v = (longint'(1) <<< (OUT_W - 1)) - 1;
                o = 1'b1;
            end else if (r < -(longint'(1) <<< (OUT_W - 1))) begin
                v = -(longint'(1) <<< (OUT_W - 1));
                o = 1'b1;
            end
        end
    endfunction

    // Per-cycle compare, then advance the group-level model.
    always @(negedge clk) begin
        bit exp_ir;
        longint s;
        exp_ir = !rst && !m_flush && !m_hold;
        chk("in_ready", in_ready, exp_ir);
        chk("s_in_ready", s_in_ready, exp_ir);
        chk("out_valid", out_valid, m_hold);
        chk("s_out_valid", s_out_valid, m_hold);
        if (m_hold) begin
            chk("d_out", d_out, m_eu);
            chk("ovf", ovf, m_ou);
            chk("s_d_out", $signed(s_d_out), m_es);
            chk("s_ovf", s_ovf, m_os);
        end
        if (rst) begin
            m_beats = 0;
            m_f = 0;
            m_flush = 1'b0;
            m_hold = 1'b0;
        end else begin
            if (m_hold && out_ready) begin
                m_hold = 1'b0;
                last_hs_cyc = cyc;
            end
            if (m_flush) begin
                m_flush = 1'b0;
                m_hold = 1'b1;
            end
            if (in_valid && exp_ir) begin
                s = beat_sum();
                m_f = (m_beats == 0) ? longint'(bias) + s : m_f + s;
                m_beats++;
                if (m_beats == BEATS) begin
                    m_beats = 0;
                    m_flush = 1'b1;
                    post(m_f, 1'b1, m_eu, m_ou);
                    post(m_f, 1'b0, m_es, m_os);
                end
            end
        end
    end

    task automatic set_uni(input logic [N-1:0] d, input logic [M-1:0] wv);
        for (int i = 0; i < TAPS; i++) begin
            data2conv[i*N +: N] = d;
            w[i*M +: M] = wv;
        end
    endtask

    task automatic set_rand();
        int mode;
        mode = $urandom_range(0, 7);
        for (int i = 0; i < TAPS; i++) begin
            if (mode == 0) begin
                data2conv[i*N +: N] = 4'd15;
                w[i*M +: M] = 4'd7;
            end else if (mode == 1) begin
                data2conv[i*N +: N] = 4'd15;
                w[i*M +: M] = 4'b1000;
            end else begin
                data2conv[i*N +: N] = N'($urandom_range(0, 15));
                w[i*M +: M] = M'($urandom_range(0, 15));
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_or) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic beat(input logic signed [BIAS_W-1:0] b);
        bit got;
        got = 1'b0;
        bias = b;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                last_acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (rnd_or) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!got) chk("beat_timeout", 0, 1);
    endtask

    task automatic group(input logic signed [BIAS_W-1:0] b);
        repeat (BEATS) beat(b);
    endtask

    task automatic wait_result(input string nm, input longint eu, input bit ou,
                               input longint es, input bit os, input bit lat);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        if (!got) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            chk({nm, "_d"}, d_out, eu);
            chk({nm, "_ovf"}, ovf, ou);
            chk({nm, "_sd"}, $signed(s_d_out), es);
            chk({nm, "_sovf"}, s_ovf, os);
            if (lat) chk({nm, "_lat"}, cyc - last_acc_cyc, 2);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [BIAS_W-1:0] rb;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk);
        #1;

        set_uni(4'd1, 4'd1);
        group(16'sd0);
        wait_result("basic", 36, 0, 36, 0, 1);
        group(16'sd2);
        wait_result("bias2", 37, 0, 37, 0, 1);
        group(-16'sd146);
        wait_result("biasneg", 0, 0, 0, 0, 1);

        set_uni(4'd15, 4'd7);
        group(16'sd0);
        wait_result("satpos", 255, 1, 127, 1, 1);
        set_uni(4'd15, 4'b1000);
        group(16'sd0);
        wait_result("satneg", 0, 0, -128, 1, 1);

        set_uni(4'd1, 4'd1);
        out_ready = 1'b0;
        group(16'sd0);
        wait_result("hold", 36, 0, 36, 0, 1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_d", d_out, 36);
            chk("hold_ir", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        beat(16'sd0);
        chk("next_accept", last_acc_cyc - last_hs_cyc, 1);
        repeat (BEATS - 1) beat(16'sd0);
        wait_result("after_hold", 36, 0, 36, 0, 1);

        beat(16'sd0);
        idle(2);
        beat(16'sd100);
        idle(1);
        beat(-16'sd50);
        beat(16'sd7);
        wait_result("gaps", 36, 0, 36, 0, 1);

        beat(16'sd0);
        beat(16'sd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        group(16'sd0);
        wait_result("midrst", 36, 0, 36, 0, 1);

        out_ready = 1'b0;
        set_uni(4'd2, 4'd3);
        group(16'sd0);
        wait_result("holdrst_pre", 216, 0, 127, 1, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("holdrst_valid", out_valid, 0);
        chk("holdrst_ir", in_ready, 1);
        @(posedge clk);
        #1;
        set_uni(4'd1, 4'd1);
        group(16'sd0);
        wait_result("holdrst", 36, 0, 36, 0, 1);

        rnd_or = 1'b1;
        for (int g = 0; g < 150; g++) begin
            for (int j = 0; j < BEATS; j++) begin
                set_rand();
                if ($urandom_range(0, 3) == 0) rb = BIAS_W'($urandom);
                else rb = BIAS_W'(int'($urandom_range(0, 400)) - 200);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                beat(rb);
                if (g % 25 == 24 && j == 1) begin
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                end
            end
        end
        rnd_or = 1'b0;
        out_ready = 1'b1;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
